// File: rtl/rv_regfile_mp_pkg.sv
// Shared definitions for the multi-port RISC-V register file.
//   XLEN_DEFAULT       : default register width
//   NREGS_RV32E/RV32I  : the two supported register counts
//   rf_state_e         : clear/run controller states
//   idx_illegal()      : true when a 5-bit register index falls outside the array
package rv_regfile_mp_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREGS_RV32E  = 16;
    localparam int NREGS_RV32I  = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    // A 5-bit index can only exceed the array when the array is RV32E-sized;
    // for 32 entries this folds to constant 0.
    function automatic logic idx_illegal(input logic [4:0] idx, input int nregs);
        return {1'b0, idx} >= 6'(nregs);
    endfunction

endpackage

// File: rtl/rv_regfile_mp_regmem.sv
// Register array slice: one synchronous read port and one write port.
// One copy exists per read lane; all copies receive the same writes.
//   clk, rst_n : clock, async active-low reset (read register only)
//   re, raddr  : read enable and address; rdata registered
//   we, waddr, wdata : write port
// The storage array has no reset; it is zeroed by the owner's clear sequence.
module rv_regmem_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read returns the pre-write contents on a same-address collision;
    // the owner covers that case with its write bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-read-port RISC-V integer register file with X/W bypass and a
// hardware clear sequence that zeroes every register after reset or on request.
//   clk_i, rst_n_i          : clock, async active-low reset
//   d_stall_i               : holds the read registers when high
//   rf_rs_i                 : per-lane read index (5 bits per lane)
//   d_rs_i                  : per-lane index compared against the X bypass
//   x_rs_value_o            : per-lane operand (XLEN bits per lane)
//   x_rs_illegal_o          : per-lane registered out-of-range index flag
//   w_rd_i/w_rd_value_i/w_rd_store_i       : write port
//   w_bypass_rd_write_i/w_bypass_rd_value_i : X-stage forward
//   clear_i                 : pulse restarting the clear sequence
//   ready_o                 : high while in RUN
module rv_regfile_mp
    import rv_regfile_mp_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_RV32I,
    parameter int NUM_RD = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   d_stall_i,
    input  logic [5*NUM_RD-1:0]    rf_rs_i,
    input  logic [5*NUM_RD-1:0]    d_rs_i,
    output logic [XLEN*NUM_RD-1:0] x_rs_value_o,
    output logic [NUM_RD-1:0]      x_rs_illegal_o,
    input  logic [4:0]             w_rd_i,
    input  logic [XLEN-1:0]        w_rd_value_i,
    input  logic                   w_rd_store_i,
    input  logic                   w_bypass_rd_write_i,
    input  logic [XLEN-1:0]        w_bypass_rd_value_i,
    input  logic                   clear_i,
    output logic                   ready_o
);

    localparam int         AW   = $clog2(NREGS);
    localparam logic [4:0] LAST = 5'(NREGS - 1);

    rf_state_e       state;
    logic [4:0]      cnt;
    logic            clearing;
    logic            run_write;
    logic            wr_en;
    logic [4:0]      wr_idx;
    logic [XLEN-1:0] wr_data;
    logic            rd_en;

    assign clearing  = (state == ST_CLEAR);
    assign run_write = w_rd_store_i && (w_rd_i != '0) && !idx_illegal(w_rd_i, NREGS) && !clearing;

    // The clear sequence borrows the write port, so the W bypass also sees
    // clear writes and a read colliding with the last cleared entry returns 0.
    assign wr_en   = run_write || clearing;
    assign wr_idx  = clearing ? cnt : w_rd_i;
    assign wr_data = clearing ? '0 : w_rd_value_i;
    assign rd_en   = !d_stall_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_CLEAR;
            cnt     <= '0;
            ready_o <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_i) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        ready_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_RUN: begin
                    if (clear_i) begin
                        state   <= ST_CLEAR;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    cnt     <= '0;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_lane
        logic [4:0]      rs;
        logic [4:0]      ds;
        logic [XLEN-1:0] mem_q;
        logic [XLEN-1:0] wdat_q;
        logic            wbyp_q;
        logic            ill_q;
        logic            xbyp;
        logic [XLEN-1:0] val;

        assign rs = rf_rs_i[5*k +: 5];
        assign ds = d_rs_i[5*k +: 5];

        rv_regmem_mp #(
            .XLEN  (XLEN),
            .NREGS (NREGS)
        ) u_mem (
            .clk   (clk_i),
            .rst_n (rst_n_i),
            .re    (rd_en),
            .raddr (rs[AW-1:0]),
            .rdata (mem_q),
            .we    (wr_en),
            .waddr (wr_idx[AW-1:0]),
            .wdata (wr_data)
        );

        // ---- read stage -> X stage boundary ----
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                wbyp_q <= 1'b0;
                ill_q  <= 1'b0;
            end else if (rd_en) begin
                wbyp_q <= wr_en && (rs == wr_idx);
                ill_q  <= idx_illegal(rs, NREGS);
            end
        end

        // Only consumed when wbyp_q is set, so it needs no reset.
        always_ff @(posedge clk_i) begin
            if (rd_en) begin
                wdat_q <= wr_data;
            end
        end

        assign xbyp = w_bypass_rd_write_i && (w_rd_i == ds) && (w_rd_i != '0);

        always_comb begin
            val = mem_q;
            if (clearing || ill_q) begin
                val = '0;
            end else if (xbyp) begin
                val = w_bypass_rd_value_i;
            end else if (wbyp_q) begin
                val = wdat_q;
            end
        end

        assign x_rs_value_o[XLEN*k +: XLEN] = val;
        assign x_rs_illegal_o[k]            = ill_q;
    end

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Self-checking bench for rv_regfile_mp: a 32-entry and a 16-entry instance
// share all inputs; read results are scoreboarded one cycle after issue.
module tb_rv_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n, d_stall, clear, w_store, w_byp;
    logic [9:0]  rf_rs, d_rs;
    logic [4:0]  w_rd;
    logic [31:0] w_val, w_byp_val;
    logic [63:0] val32, val16;
    logic [1:0]  ill32, ill16;
    logic        rdy32, rdy16;

    always #5 clk = ~clk;

    rv_regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .d_stall_i(d_stall), .rf_rs_i(rf_rs), .d_rs_i(d_rs),
        .x_rs_value_o(val32), .x_rs_illegal_o(ill32), .w_rd_i(w_rd), .w_rd_value_i(w_val),
        .w_rd_store_i(w_store), .w_bypass_rd_write_i(w_byp), .w_bypass_rd_value_i(w_byp_val),
        .clear_i(clear), .ready_o(rdy32)
    );

    rv_regfile_mp #(.XLEN(32), .NREGS(16), .NUM_RD(2)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .d_stall_i(d_stall), .rf_rs_i(rf_rs), .d_rs_i(d_rs),
        .x_rs_value_o(val16), .x_rs_illegal_o(ill16), .w_rd_i(w_rd), .w_rd_value_i(w_val),
        .w_rd_store_i(w_store), .w_bypass_rd_write_i(w_byp), .w_bypass_rd_value_i(w_byp_val),
        .clear_i(clear), .ready_o(rdy16)
    );

    typedef struct {
        logic        store;
        logic [4:0]  rd;
        logic [31:0] wval;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [1:0]  ill16;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until ready, checking both instances along the way.
    task automatic run_clear_sequence(input string tag);
        int bad32;
        int bad16;
        bad32 = 0;
        bad16 = 0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (rdy32 !== 1'b0) bad32++;
            if (rdy16 !== (i >= 16)) bad16++;
        end
        check({tag, "_ready32_low_cycles"}, bad32, 0);
        check({tag, "_ready16_profile"}, bad16, 0);
        tick();
        check({tag, "_ready32_high"}, {31'd0, rdy32}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[8];
        exp_t e;
        int   bad;

        vt[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd0,  5'd5,  32'h0,        32'h0};
        vt[1] = '{1'b1, 5'd10, 32'h11111111, 5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd10, 32'h12345678, 32'h11111111};
        vt[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h12345678};
        vt[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd0,  32'hCAFEF00D, 32'h0};
        vt[5] = '{1'b0, 5'd3,  32'h00000BAD, 5'd3,  5'd31, 32'hDEADBEEF, 32'hCAFEF00D};
        vt[6] = '{1'b1, 5'd4,  32'h00000055, 5'd4,  5'd1,  32'h00000055, 32'h0};
        vt[7] = '{1'b0, 5'd0,  32'h0,        5'd20, 5'd3,  32'h0,        32'hDEADBEEF};

        rst_n = 1'b0; d_stall = 1'b0; clear = 1'b0; w_store = 1'b0; w_byp = 1'b0;
        rf_rs = '0; d_rs = '0; w_rd = '0; w_val = '0; w_byp_val = '0;

        // Reset state
        tick();
        tick();
        check("rst_ready32", {31'd0, rdy32}, 32'd0);
        check("rst_ready16", {31'd0, rdy16}, 32'd0);
        check("rst_val32_l0", val32[31:0], 32'd0);
        check("rst_val32_l1", val32[63:32], 32'd0);
        check("rst_ill16", {30'd0, ill16}, 32'd0);

        // Release: full clear of NREGS cycles
        rst_n = 1'b1;
        run_clear_sequence("boot");

        // Table-driven read/write vectors
        for (int i = 0; i < 8; i++) begin
            w_store = vt[i].store;
            w_rd    = vt[i].rd;
            w_val   = vt[i].wval;
            rf_rs   = {vt[i].rs1, vt[i].rs0};
            e.idx   = i;
            e.e0    = vt[i].e0;
            e.e1    = vt[i].e1;
            e.f0    = (vt[i].rs0 >= 5'd16) ? 32'd0 : vt[i].e0;
            e.f1    = (vt[i].rs1 >= 5'd16) ? 32'd0 : vt[i].e1;
            e.ill16 = {vt[i].rs1 >= 5'd16, vt[i].rs0 >= 5'd16};
            sbq.push_back(e);
            tick();
            e = sbq.pop_front();
            check($sformatf("v%0d_r32_l0", e.idx), val32[31:0], e.e0);
            check($sformatf("v%0d_r32_l1", e.idx), val32[63:32], e.e1);
            check($sformatf("v%0d_r16_l0", e.idx), val16[31:0], e.f0);
            check($sformatf("v%0d_r16_l1", e.idx), val16[63:32], e.f1);
            check($sformatf("v%0d_ill16", e.idx), {30'd0, ill16}, {30'd0, e.ill16});
            check($sformatf("v%0d_ill32", e.idx), {30'd0, ill32}, 32'd0);
        end
        w_store = 1'b0;

        // Stall holds the read register
        rf_rs = {5'd0, 5'd3};
        tick();
        check("stall_pre", val32[31:0], 32'hDEADBEEF);
        d_stall = 1'b1;
        rf_rs   = {5'd0, 5'd4};
        tick();
        check("stall_hold", val32[31:0], 32'hDEADBEEF);
        d_stall = 1'b0;
        tick();
        check("stall_release", val32[31:0], 32'h00000055);

        // X bypass beats W bypass and array
        w_store = 1'b1; w_rd = 5'd9; w_val = 32'h1; rf_rs = {5'd9, 5'd0};
        tick();
        w_store = 1'b0; w_byp = 1'b1; w_byp_val = 32'hA5A5A5A5; d_rs = {5'd9, 5'd2};
        #1;
        check("xbyp_l1_32", val32[63:32], 32'hA5A5A5A5);
        check("xbyp_l1_16", val16[63:32], 32'hA5A5A5A5);
        check("xbyp_l0_none", val32[31:0], 32'h0);
        w_byp = 1'b0;
        #1;
        check("wbyp_after_xbyp", val32[63:32], 32'h1);
        tick();
        check("array_x9", val32[63:32], 32'h1);

        // Writes and bypasses aimed at x0 never show up
        w_store = 1'b1; w_rd = 5'd0; w_val = 32'hFFFFFFFF;
        w_byp = 1'b1; w_byp_val = 32'hFFFFFFFF; d_rs = '0; rf_rs = '0;
        tick();
        check("x0_l0", val32[31:0], 32'h0);
        check("x0_l1", val32[63:32], 32'h0);
        w_store = 1'b0; w_byp = 1'b0;

        // clear_i in RUN; stores during CLEAR must be ignored
        rf_rs = {5'd4, 5'd4};
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_ready_fall", {31'd0, rdy32}, 32'd0);
        check("clr_lane_zero", val32[31:0], 32'h0);
        w_store = 1'b1; w_rd = 5'd4; w_val = 32'h77;
        run_clear_sequence("clr");
        w_store = 1'b0;
        #1;
        check("clr_x4_l0", val32[31:0], 32'h0);
        check("clr_x4_l1", val32[63:32], 32'h0);

        // Reset at cnt=10 restarts the whole clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        rf_rs = {5'd20, 5'd20};
        for (int i = 0; i < 10; i++) tick();
        check("pre_rst_ill16", {30'd0, ill16}, 32'd3);
        rst_n = 1'b0;
        #1;
        bad = 0;
        if (rdy32 !== 1'b0) bad++;
        if (rdy16 !== 1'b0) bad++;
        check("midrst_ready", bad, 0);
        check("midrst_ill16", {30'd0, ill16}, 32'd0);
        check("midrst_val16_l0", val16[31:0], 32'd0);
        tick();
        rst_n = 1'b1;
        rf_rs = '0;
        run_clear_sequence("rst10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
